fifo_stream_drain: RTL and testbench

//   Read-side drain stage placed directly downstream of the synchronous linear FIFO.

---
 rtl/fifo_stream_drain_pkg.sv | 23 ++
 rtl/fifo_stream_drain_if.sv | 22 ++
 rtl/fifo_stream_drain_skid_buffer.sv | 47 ++++
 rtl/fifo_stream_drain.sv | 76 +++++++
 tb/tb_fifo_stream_drain.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_drain_pkg.sv
// Shared definitions for the FIFO drain stage: word width and
// buffer pointer/occupancy widths derived from the buffer depth.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package fifo_stream_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_STALL
   } drain_state_e;

   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_stream_drain_if.sv
// FIFO read port plus valid/ready stream port of the drain stage.
// master = drain side, slave = FIFO and consumer side.
interface fifo_stream_drain_if #(
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   logic                  FIFO_EMPTY;
   logic [DATA_WIDTH-1:0] FIFO_DATA;
   logic                  FIFO_RD_EN;
   logic [DATA_WIDTH-1:0] M_DATA;
   logic                  M_VALID;
   logic                  M_READY;

   modport master (
      input  FIFO_EMPTY, FIFO_DATA, M_READY,
      output FIFO_RD_EN, M_DATA, M_VALID
   );

   modport slave (
      output FIFO_EMPTY, FIFO_DATA, M_READY,
      input  FIFO_RD_EN, M_DATA, M_VALID
   );
endinterface

// File: rtl/fifo_stream_drain_skid_buffer.sv
// drain_skid_buffer: circular word buffer with head/tail pointers
// and occupancy; push writes at tail, pop advances head.
module drain_skid_buffer
   import fifo_stream_drain_pkg::*;
#(
   parameter int  DATA_WIDTH = `DATA_WIDTH,
   parameter int  BUF_DEPTH  = 3,
   localparam int PW         = ptr_width(BUF_DEPTH),
   localparam int OW         = occ_width(BUF_DEPTH)
) (
   input  logic                  FCLK,
   input  logic                  FRST,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OW-1:0]         occ
);
   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge FCLK) begin
      if (FRST) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= bump(tail);
         end
         if (pop)
            head <= bump(head);
         occ <= occ + OW'(push) - OW'(pop);
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops the upstream FIFO against buffer credits
// and re-presents the returned words as a valid/ready stream.
module fifo_stream_drain
   import fifo_stream_drain_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int BUF_DEPTH  = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 FCLK,
   input  logic                 FRST,
   input  logic                 ENABLE,
   fifo_stream_drain_if.master  bus,
   output logic [CNT_WIDTH-1:0] WORD_COUNT
);
   localparam int OW = occ_width(BUF_DEPTH);

   logic          inflight;
   logic [OW-1:0] occ;
   logic          handshake;
   int            load;
   int            load_n;
   drain_state_e  state_q;
   drain_state_e  state_n;

   // Credits use registered occ/inflight only, so M_READY never reaches RD_EN.
   assign load           = int'(occ) + int'(inflight);
   assign bus.M_VALID    = (occ != '0);
   assign handshake      = bus.M_VALID && bus.M_READY;
   assign bus.FIFO_RD_EN = !FRST && ENABLE && !bus.FIFO_EMPTY
                           && (load < BUF_DEPTH);

   drain_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .FCLK      (FCLK),
      .FRST      (FRST),
      .push      (inflight),
      .push_data (bus.FIFO_DATA),
      .pop       (handshake),
      .head_data (bus.M_DATA),
      .occ       (occ)
   );

   always_ff @(posedge FCLK) begin
      if (FRST) begin
         inflight   <= 1'b0;
         WORD_COUNT <= '0;
         state_q    <= ST_IDLE;
      end else begin
         inflight <= bus.FIFO_RD_EN;
         if (handshake)
            WORD_COUNT <= WORD_COUNT + CNT_WIDTH'(1);
         state_q <= state_n;
      end
   end

   always_comb begin
      load_n  = load - int'(handshake) + int'(bus.FIFO_RD_EN);
      state_n = ST_STREAM;
      unique case (1'b1)
         (load_n == 0):         state_n = ST_IDLE;
         (load_n >= BUF_DEPTH): state_n = ST_STALL;
         default:               state_n = ST_STREAM;
      endcase
   end

   a_no_overflow: assert property (@(posedge FCLK) disable iff (FRST)
      load <= BUF_DEPTH);

   a_state_track: assert property (@(posedge FCLK) disable iff (FRST)
      ((state_q == ST_IDLE) == (load == 0))
      && ((state_q == ST_STALL) == (load == BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: FIFO model with registered read data,
// vector table for the basic stream plus directed corner sequences.
module tb_fifo_stream_drain;
   import fifo_stream_drain_pkg::*;

   localparam int DW = 8;
   localparam int CW = 4;

   typedef struct {
      logic       en;
      logic       rdy;
      logic       rd;
      logic       vld;
      logic [7:0] data;
      logic       dchk;
      logic [3:0] cnt;
   } vec_t;

   logic          FCLK = 1'b0;
   logic          FRST;
   logic          ENABLE;
   logic [CW-1:0] WORD_COUNT;

   fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_drain #(
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (3),
      .CNT_WIDTH  (CW)
   ) dut (
      .FCLK       (FCLK),
      .FRST       (FRST),
      .ENABLE     (ENABLE),
      .bus        (bus),
      .WORD_COUNT (WORD_COUNT)
   );

   always #5 FCLK = ~FCLK;

   logic [DW-1:0] mem [64];
   logic [DW-1:0] fdata = '0;
   int            wp = 0;
   int            rp = 0;
   logic [DW-1:0] exp_q [$];
   int nchk = 0;
   int nerr = 0;
   int n_rd = 0;
   int n_hs = 0;
   int out_cnt = 0;
   int max_out = 0;
   int pushed = 0;
   int last = 0;
   vec_t v [6];

   assign bus.FIFO_EMPTY = (wp == rp);
   assign bus.FIFO_DATA  = fdata;

   // Upstream FIFO: data is registered, valid the cycle after RD_EN.
   always @(posedge FCLK)
      if (bus.FIFO_RD_EN) begin
         fdata <= mem[rp[5:0]];
         rp    <= rp + 1;
      end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] d);
      mem[wp[5:0]] = d;
      wp++;
      exp_q.push_back(d);
   endtask

   task automatic sample();
      logic hs;
      hs = bus.M_VALID && bus.M_READY;
      if (FRST) begin
         out_cnt = 0;
      end else begin
         if (bus.FIFO_RD_EN)
            n_rd++;
         out_cnt = out_cnt + int'(bus.FIFO_RD_EN) - int'(hs);
         if (out_cnt > max_out)
            max_out = out_cnt;
         if (hs) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL extra_word: got %02h, expected none",
                        bus.M_DATA);
            end else begin
               chk("order", bus.M_DATA, exp_q.pop_front());
            end
         end
      end
   endtask

   task automatic cycle();
      #2;
      sample();
      @(posedge FCLK);
      #1;
   endtask

   task automatic do_reset();
      FRST = 1'b1;
      cycle();
      FRST = 1'b0;
      wp = rp;
      exp_q.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 80 && exp_q.size() != 0; i++)
         cycle();
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      v[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0};
      v[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 4'd0};
      v[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 4'd0};
      v[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 4'd1};
      v[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 4'd2};
      v[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3};

      // Reset with a non-empty FIFO and ENABLE high: no pops.
      FRST = 1'b1;
      ENABLE = 1'b1;
      bus.M_READY = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      cycle();
      cycle();
      chk("rst_rd_en", bus.FIFO_RD_EN, 0);
      chk("rst_valid", bus.M_VALID, 0);
      chk("rst_data", bus.M_DATA, 0);
      chk("rst_count", WORD_COUNT, 0);
      FRST = 1'b0;

      // Three-word burst, cycle by cycle.
      for (int i = 0; i < 6; i++) begin
         ENABLE = v[i].en;
         bus.M_READY = v[i].rdy;
         #1;
         chk($sformatf("v%0d_rd_en", i), bus.FIFO_RD_EN, v[i].rd);
         chk($sformatf("v%0d_valid", i), bus.M_VALID, v[i].vld);
         if (v[i].dchk)
            chk($sformatf("v%0d_data", i), bus.M_DATA, v[i].data);
         chk($sformatf("v%0d_count", i), WORD_COUNT, v[i].cnt);
         cycle();
      end

      // Consumer stalled with 8 words queued: exactly 3 pops.
      do_reset();
      bus.M_READY = 1'b0;
      ENABLE = 1'b1;
      for (int i = 0; i < 8; i++)
         push(8'h40 + 8'(i));
      n_rd = 0;
      repeat (6) cycle();
      chk("stall_pops", n_rd, 3);
      chk("stall_rd_en", bus.FIFO_RD_EN, 0);
      chk("stall_valid", bus.M_VALID, 1);
      chk("stall_data", bus.M_DATA, 8'h40);
      repeat (3) cycle();
      chk("stall_hold", bus.M_DATA, 8'h40);
      bus.M_READY = 1'b1;
      drain("stall_drain");
      chk("stall_count", WORD_COUNT, 8);

      // Alternating ready on a continuously refilled FIFO.
      do_reset();
      max_out = 0;
      n_hs = 0;
      pushed = 0;
      ENABLE = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.M_READY = (c % 2 == 0);
         if (wp - rp < 4 && pushed < 20) begin
            push(8'h80 + 8'(pushed));
            pushed++;
         end
         cycle();
      end
      bus.M_READY = 1'b1;
      drain("toggle_drain");
      nchk++;
      if (max_out > 3) begin
         nerr++;
         $display("FAIL toggle_credit: got %0d outstanding, limit 3",
                  max_out);
      end
      chk("toggle_words", n_hs, 20);
      chk("toggle_count", WORD_COUNT, 4);

      // Reset one cycle after a pop, with two words buffered.
      bus.M_READY = 1'b0;
      ENABLE = 1'b1;
      for (int i = 0; i < 8; i++)
         push(8'h60 + 8'(i));
      n_rd = 0;
      repeat (3) cycle();
      chk("mid_pops", n_rd, 3);
      FRST = 1'b1;
      cycle();
      FRST = 1'b0;
      #1;
      chk("mid_valid", bus.M_VALID, 0);
      chk("mid_count", WORD_COUNT, 0);
      chk("mid_data", bus.M_DATA, 0);
      repeat (3) void'(exp_q.pop_front());
      bus.M_READY = 1'b1;
      drain("mid_drain");
      chk("mid_after", WORD_COUNT, 5);

      // ENABLE dropped with one word buffered and one in flight.
      bus.M_READY = 1'b0;
      ENABLE = 1'b1;
      for (int i = 0; i < 5; i++)
         push(8'h70 + 8'(i));
      cycle();
      cycle();
      ENABLE = 1'b0;
      n_rd = 0;
      #1;
      chk("en_rd_en", bus.FIFO_RD_EN, 0);
      bus.M_READY = 1'b1;
      repeat (8) cycle();
      chk("en_no_pops", n_rd, 0);
      chk("en_count", WORD_COUNT, 7);
      chk("en_left", exp_q.size(), 3);
      ENABLE = 1'b1;
      drain("en_drain");
      chk("en_final", WORD_COUNT, 10);

      // 17 words through a 4-bit counter.
      do_reset();
      n_hs = 0;
      last = 0;
      for (int i = 0; i < 17; i++)
         push(8'h90 + 8'(i));
      ENABLE = 1'b1;
      bus.M_READY = 1'b1;
      for (int i = 0; i < 40 && n_hs < 17; i++) begin
         cycle();
         if (n_hs != last) begin
            last = n_hs;
            if (n_hs == 15)
               chk("wrap_15", WORD_COUNT, 15);
            else if (n_hs == 16)
               chk("wrap_0", WORD_COUNT, 0);
            else if (n_hs == 17)
               chk("wrap_1", WORD_COUNT, 1);
         end
      end
      chk("wrap_words", n_hs, 17);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
